// File: rtl/aes_mix_seq_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg: shared types, MixColumns coefficient constants and GF(2^8) helpers
// used by the sequential MixColumns engine (aes_mix_seq) and its column mixer.
//   state_t     : 16-byte AES state, byte 15 is the most significant byte.
//                 Column c holds bytes 15-4c (row 0) down to 12-4c (row 3).
//   col_t       : one column, element [r] is row r.
//   mix_state_e : engine FSM encoding.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [15:0][7:0] state_t;
    typedef logic [3:0][7:0]  col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_e;

    // Written in matrix-row order, so the coefficient for offset k sits at [3-k].
    localparam logic [3:0][3:0] MIX_FWD = {4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0][3:0] MIX_INV = {4'hE, 4'hB, 4'hD, 4'h9};

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] y);
        gf_xtime = y[7] ? ({y[6:0], 1'b0} ^ 8'h1B) : {y[6:0], 1'b0};
    endfunction

    // Multiply a byte by a 4-bit constant: XOR of y*x^i selected by coeff bits.
    function automatic logic [7:0] gf_mul(input logic [3:0] coeff, input logic [7:0] y);
        logic [7:0] x1;
        logic [7:0] x2;
        logic [7:0] x3;
        x1 = gf_xtime(y);
        x2 = gf_xtime(x1);
        x3 = gf_xtime(x2);
        gf_mul = ({8{coeff[0]}} & y)  ^ ({8{coeff[1]}} & x1) ^
                 ({8{coeff[2]}} & x2) ^ ({8{coeff[3]}} & x3);
    endfunction

    // Coefficient applied to input row j when producing output row r, k = (j-r) mod 4.
    function automatic logic [3:0] mix_coeff(input logic inv, input logic [1:0] k);
        mix_coeff = inv ? MIX_INV[2'd3 - k] : MIX_FWD[2'd3 - k];
    endfunction

endpackage

// File: rtl/aes_mix_col.sv
// -----------------------------------------------------------------------------
// aes_mix_col: combinational single-column MixColumns / InvMixColumns.
//   col_i : input column, [r] = row r
//   inv_i : 0 = forward matrix, 1 = inverse matrix
//   col_o : mixed column, same layout
// -----------------------------------------------------------------------------
module aes_mix_col
    import aes_pkg::*;
(
    input  col_t col_i,
    input  logic inv_i,
    output col_t col_o
);

    // Circulant matrix product: each output row is a GF-weighted XOR of all rows.
    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                col_o[r] = col_o[r] ^ gf_mul(mix_coeff(inv_i, 2'(j - r)), col_i[j]);
            end
        end
    end

endmodule

// File: rtl/aes_mix_seq.sv
// -----------------------------------------------------------------------------
// aes_mix_seq: sequential MixColumns engine, COLS_PER_CYCLE columns per beat.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input handshake (in_ready combinational from out_ready)
//   in_inv                : block mode, 0 = MixColumns, 1 = InvMixColumns
//   in_state              : 16-byte input state
//   out_valid/out_ready   : output handshake, result held while stalled
//   out_state             : mixed state (retains last result between blocks)
//   busy                  : high while columns are being mixed
// -----------------------------------------------------------------------------
module aes_mix_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  logic   in_inv,
    input  state_t in_state,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    localparam int         NBEATS    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] BEAT_LAST = 2'(NBEATS - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mix_state_e state_q, state_d;
    logic [1:0] beat_q, beat_d;
    state_t     src_q, src_d;
    state_t     res_q, res_d;
    logic       inv_q, inv_d;
    logic       accept_s;

    logic [COLS_PER_CYCLE-1:0][1:0] col_idx_s;
    col_t lane_in_s  [COLS_PER_CYCLE];
    col_t lane_out_s [COLS_PER_CYCLE];

    // Lane g mixes column beat*COLS+g; byte index 15-4c-r equals ~{c,r}.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_idx_s[g] = beat_q * 2'(COLS_PER_CYCLE) + 2'(g);
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign lane_in_s[g][r] = src_q[~{col_idx_s[g], 2'(r)}];
        end
        aes_mix_col u_mix (
            .col_i (lane_in_s[g]),
            .inv_i (inv_q),
            .col_o (lane_out_s[g])
        );
    end

    assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign out_state = res_q;

    // Next-state: FSM transitions, beat counter, source capture and result writes.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        src_d   = src_q;
        inv_d   = inv_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    for (int r = 0; r < 4; r++) begin
                        res_d[~{col_idx_s[g], 2'(r)}] = lane_out_s[g][r];
                    end
                end
                if (beat_q == BEAT_LAST) begin
                    state_d = ST_DONE;
                    beat_d  = 2'd0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept_s) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
            end
        endcase
        if (accept_s) begin
            src_d  = in_state;
            inv_d  = in_inv;
            beat_d = 2'd0;
        end else begin
            src_d  = src_q;
            inv_d  = inv_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
            src_q   <= '0;
            inv_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            src_q   <= src_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/aes_mix_seq.md
Name: aes_mix_seq

Overview:
- Sequential, parametrised MixColumns engine for the AES datapath.
- Performs forward MixColumns (encrypt) or InvMixColumns (decrypt), selected per block.
- Processes COLS_PER_CYCLE columns per clock, trading area against latency.
- Sits between ShiftRows and AddRoundKey in the round pipeline, with valid/ready handshakes on both sides.

Parameters:
- COLS_PER_CYCLE, 1: columns mixed per beat. Legal values are 1, 2, 4; any other value is an elaboration error.
- NBEATS, 4/COLS_PER_CYCLE: derived localparam, not overridable. Beats per block.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input block present.
- in_ready  out  1  engine can accept a block.
- in_inv  in  1  0 = forward MixColumns, 1 = InvMixColumns. Sampled with the block.
- in_state  in  8 x [15:0]  state bytes. Column c = bytes 15-4c (row 0) down to 12-4c (row 3).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_state  out  8 x [15:0]  mixed state, same byte layout as in_state.
- busy  out  1  high in BUSY state.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE, beat counter 0, out_valid 0, busy 0, out_state all 0x00.
  - in_ready is 0 while rst_n=0 and 1 in IDLE after reset.
- in_ready = (IDLE) | (DONE & out_ready). This is combinational from out_ready.
- Accept: at an edge with in_valid & in_ready:
  - latch in_state into the source register and in_inv into the mode register.
  - beat counter goes to 0 and the FSM goes to BUSY.
- BUSY, each edge:
  - mixes columns beat*COLS_PER_CYCLE .. beat*COLS_PER_CYCLE+COLS_PER_CYCLE-1 of the source register.
  - writes only those columns of the result register.
  - increments the beat counter.
  - on beat NBEATS-1, goes to DONE with out_valid=1.
- Column order is ascending: column 0 (bytes 15..12) first.
- Latency: out_valid is high exactly NBEATS cycles after the accepting edge (4 / 2 / 1 cycles for COLS = 1 / 2 / 4).
- DONE:
  - out_state and out_valid are held stable while out_ready=0. No change is permitted.
  - On out_ready=1 the result is consumed.
  - If in_valid is also 1 in the same cycle, the new block is accepted on that edge and the FSM goes directly to BUSY. Otherwise it goes to IDLE.
- Throughput: one block per NBEATS+1 cycles with continuous valid/ready.
- in_valid while BUSY: ignored (in_ready=0). The source must hold the block.
- out_state is valid only while out_valid=1. Between blocks it retains the last result.
- Arithmetic is GF(2^8) with polynomial 0x11B.
  - xtime(y) = y[7] ? (y<<1)^0x1B : y<<1, truncated to 8 bits.
  - Forward matrix rows: (2,3,1,1), (3,1,1,2) rotated, i.e. r0=2a^3b^c^d, r1=a^2b^3c^d, r2=a^b^2c^3d, r3=3a^b^c^2d.
  - Inverse matrix uses coefficients 0E, 0B, 0D, 09 in the same rotation: r0=Ea^Bb^Dc^9d, etc.
- Mode is per block. in_inv is ignored except at the accepting edge.
- Reset mid-operation (BUSY or DONE): the block is discarded, all outputs return to reset values, and no out_valid pulse is produced.

Decomposition:
- Package aes_pkg:
  - function gf_xtime(byte).
  - function gf_mul(4-bit coeff, byte), implemented as an XOR of y, xtime, xtime^2, xtime^3 selected by coeff bits.
  - constants MIX_FWD = {2,3,1,1} and MIX_INV = {E,B,D,9}.
  - typedef for the 16-byte state array.
- Sub-module aes_mix_col: combinational, inputs 4 bytes plus inv, outputs 4 bytes. It is instantiated COLS_PER_CYCLE times inside a generate loop. The column slice is selected by the beat counter.

Test Plan:
- Forward, COLS=1:
  - Stimulus: column 0 = db 13 53 45, col1 = f2 0a 22 5c, col2 = 01 01 01 01, col3 = c6 c6 c6 c6, in_inv=0.
  - Response: out_valid exactly 4 cycles after accept; columns 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6.
- Inverse round-trip, COLS=2:
  - Stimulus: feed the previous output with in_inv=1.
  - Response: original db 13 53 45 / f2 0a 22 5c / 01.. / c6.. returned after 2 cycles.
- COLS=4 FIPS-197 round-1 vectors: columns d4 bf 5d 30 -> 04 66 81 e5 and e0 b4 52 ae -> e0 cb 19 9a, with a 1-cycle latency.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE.
  - Response: out_state and out_valid stable, in_ready=0. Then assert out_ready and in_valid together; the next block is accepted on the same edge and busy=1 the next cycle.
- Reset mid-BUSY:
  - Stimulus: drop rst_n at beat 2 (COLS=1).
  - Response: out_valid=0, out_state=0, in_ready=1 after release, no result emitted.
- Mode sampling: toggle in_inv during BUSY -> the result matches the mode latched at accept.
